// File: rtl/id_ctrl_pkg.sv
// Shared types and opcode constants for the instruction-decode control stage.
package id_ctrl_pkg;

  typedef enum logic [1:0] {
    TypeR    = 2'd0,
    TypeJ    = 2'd1,
    TypeHalt = 2'd2,
    TypeI    = 2'd3
  } instr_type_e;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_BNE = 6'b000101;
  localparam logic [2:0] OPC_ALUI_PREFIX = 3'b001;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Control bundle for an opcode already known to be I-type.
  function automatic ctrl_t itype_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NONE;
    if (op == OPC_LW) begin
      c.mem_read  = 1'b1;
      c.reg_write = 1'b1;
    end else if (op == OPC_SW) begin
      c.mem_write = 1'b1;
    end else if (op == OPC_BEQ || op == OPC_BNE) begin
      c.branch = 1'b1;
    end else if (op[5:3] == OPC_ALUI_PREFIX) begin
      c.reg_write = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational opcode classifier: instruction type plus control bundle.
module id_ctrl_decode
  import id_ctrl_pkg::*;
#(
  parameter int unsigned     OP_W    = 6,
  parameter logic [OP_W-1:0] OP_R    = 6'b000000,
  parameter logic [OP_W-1:0] OP_J    = 6'b000010,
  parameter logic [OP_W-1:0] OP_HALT = 6'b111111
) (
  input  logic [OP_W-1:0] i_opcode,
  output instr_type_e     o_type,
  output ctrl_t           o_ctrl
);

  always_comb begin
    o_type = TypeI;
    o_ctrl = CTRL_NONE;
    if (i_opcode == OP_R) begin
      o_type           = TypeR;
      o_ctrl.reg_write = 1'b1;
    end else if (i_opcode == OP_J) begin
      o_type      = TypeJ;
      o_ctrl.jump = 1'b1;
    end else if (i_opcode == OP_HALT) begin
      o_type = TypeHalt;
    end else begin
      o_type = TypeI;
      o_ctrl = itype_ctrl(6'(i_opcode));
    end
  end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered decode control stage with valid/ready handshake, flush and HALT drain FSM.
// Optional retired-type counters are built when IDCTL_PERF_CNT_EN is defined.
module id_ctrl_stage
  import id_ctrl_pkg::*;
#(
  parameter int unsigned        INSTR_W = 32,
  parameter int unsigned        OP_W    = 6,
  parameter logic [OP_W-1:0]    OP_R    = 6'b000000,
  parameter logic [OP_W-1:0]    OP_J    = 6'b000010,
  parameter logic [OP_W-1:0]    OP_HALT = 6'b111111,
  parameter int unsigned        CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OP_W-1:0]    out_opcode,
  output logic [1:0]         out_type,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               halted
`ifdef IDCTL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt_r,
  output logic [CNT_W-1:0]   cnt_i,
  output logic [CNT_W-1:0]   cnt_j
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e             r_state;
  logic               r_out_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [OP_W-1:0]    r_opcode;
  instr_type_e        r_type;
  ctrl_t              r_ctrl;
  logic               r_halted;

  logic [OP_W-1:0]    w_opcode;
  instr_type_e        w_type;
  ctrl_t              w_ctrl;
  logic               w_accept;
  logic               w_fire;

  assign w_opcode = instruction[INSTR_W-1 -: OP_W];

  id_ctrl_decode #(
    .OP_W    (OP_W),
    .OP_R    (OP_R),
    .OP_J    (OP_J),
    .OP_HALT (OP_HALT)
  ) u_decode (
    .i_opcode (w_opcode),
    .o_type   (w_type),
    .o_ctrl   (w_ctrl)
  );

  assign in_ready = (r_state == StRun) && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  // A flushed bundle is squashed, so its handshake neither retires nor halts.
  assign w_fire   = r_out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StRun;
      r_out_valid <= 1'b0;
      r_instr     <= '0;
      r_opcode    <= '0;
      r_type      <= TypeR;
      r_ctrl      <= CTRL_NONE;
      r_halted    <= 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (flush) begin
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_instr     <= instruction;
            r_opcode    <= w_opcode;
            r_type      <= w_type;
            r_ctrl      <= w_ctrl;
            if (w_type == TypeHalt) begin
              r_state <= StDrain;
            end
          end else if (w_fire) begin
            r_out_valid <= 1'b0;
          end
        end
        StDrain: begin
          if (flush) begin
            r_out_valid <= 1'b0;
            r_state     <= StRun;
          end else if (w_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= StHalted;
            r_halted    <= 1'b1;
          end
        end
        StHalted: begin
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= StRun;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign out_instr  = r_instr;
  assign out_opcode = r_opcode;
  assign out_type   = r_type;
  assign reg_write  = r_ctrl.reg_write;
  assign mem_read   = r_ctrl.mem_read;
  assign mem_write  = r_ctrl.mem_write;
  assign branch     = r_ctrl.branch;
  assign jump       = r_ctrl.jump;
  assign halted     = r_halted;

`ifdef IDCTL_PERF_CNT_EN
  logic [CNT_W-1:0] r_cnt_r;
  logic [CNT_W-1:0] r_cnt_i;
  logic [CNT_W-1:0] r_cnt_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_r <= '0;
      r_cnt_i <= '0;
      r_cnt_j <= '0;
    end else if (w_fire) begin
      if (r_type == TypeR && r_cnt_r != '1) r_cnt_r <= r_cnt_r + 1'b1;
      if (r_type == TypeI && r_cnt_i != '1) r_cnt_i <= r_cnt_i + 1'b1;
      if (r_type == TypeJ && r_cnt_j != '1) r_cnt_j <= r_cnt_j + 1'b1;
    end
  end

  assign cnt_r = r_cnt_r;
  assign cnt_i = r_cnt_i;
  assign cnt_j = r_cnt_j;
`endif

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed self-checking bench for id_ctrl_stage; counter checks build with IDCTL_PERF_CNT_EN.
module tb_id_ctrl_stage;

  localparam int unsigned CNT_W = 4;

  localparam logic [31:0] I_R    = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8C880004;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_ADDI = 32'h20080005;
  localparam logic [31:0] I_SW   = 32'hAC880008;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_BEQ  = 32'h10220003;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [1:0]  out_type;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump;
  logic        halted;
`ifdef IDCTL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cnt_j;
`endif

  int n_checks = 0;
  int n_errors = 0;

  id_ctrl_stage #(
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_type    (out_type),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .jump        (jump),
    .halted      (halted)
`ifdef IDCTL_PERF_CNT_EN
    ,
    .cnt_r       (cnt_r),
    .cnt_i       (cnt_i),
    .cnt_j       (cnt_j)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control bits packed as {reg_write, mem_read, mem_write, branch, jump}.
  function automatic logic [31:0] ctrl_bits();
    return {27'd0, reg_write, mem_read, mem_write, branch, jump};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_type", {30'd0, out_type}, 32'd0);
    chk("rst_ctrl", ctrl_bits(), 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef IDCTL_PERF_CNT_EN
    chk("rst_cnt_r", 32'(cnt_r), 32'd0);
`endif

    // Stream R, LW, J with downstream always ready.
    out_ready = 1'b1; in_valid = 1'b1; instruction = I_R;
    tick();
    chk("r_valid", {31'd0, out_valid}, 32'd1);
    chk("r_type", {30'd0, out_type}, 32'd0);
    chk("r_instr", out_instr, I_R);
    chk("r_ctrl", ctrl_bits(), 32'b10000);
    instruction = I_LW;
    tick();
    chk("lw_type", {30'd0, out_type}, 32'd3);
    chk("lw_opcode", {26'd0, out_opcode}, 32'b100011);
    chk("lw_ctrl", ctrl_bits(), 32'b11000);
    instruction = I_J;
    tick();
    chk("j_type", {30'd0, out_type}, 32'd1);
    chk("j_ctrl", ctrl_bits(), 32'b00001);
    in_valid = 1'b0;
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);
`ifdef IDCTL_PERF_CNT_EN
    chk("stream_cnt_r", 32'(cnt_r), 32'd1);
    chk("stream_cnt_i", 32'(cnt_i), 32'd1);
    chk("stream_cnt_j", 32'(cnt_j), 32'd1);
`endif

    // Backpressure: ADDI held for 3 cycles, SW waits and loads on release.
    out_ready = 1'b0; in_valid = 1'b1; instruction = I_ADDI;
    tick();
    chk("addi_ctrl", ctrl_bits(), 32'b10000);
    instruction = I_SW;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stable", out_instr, I_ADDI);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sw_instr", out_instr, I_SW);
    chk("sw_ctrl", ctrl_bits(), 32'b00100);
    in_valid = 1'b0;
    tick();
`ifdef IDCTL_PERF_CNT_EN
    chk("bp_cnt_i", 32'(cnt_i), 32'd3);
`endif

    // HALT accepted with downstream stalled, then drained.
    out_ready = 1'b0; in_valid = 1'b1; instruction = I_HALT;
    tick();
    in_valid = 1'b0;
    #1;
    chk("halt_type", {30'd0, out_type}, 32'd2);
    chk("halt_ctrl", ctrl_bits(), 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
    chk("drain_halted", {31'd0, halted}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("halted_set", {31'd0, halted}, 32'd1);
    chk("halted_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; instruction = I_R;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("halted_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("halted_no_load", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("halted_flush_sticky", {31'd0, halted}, 32'd1);
`ifdef IDCTL_PERF_CNT_EN
    chk("halt_not_counted", 32'(cnt_r), 32'd1);
`endif

    // Reset clears halted asynchronously.
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst = 1'b0;

    // HALT in DRAIN squashed by flush, then BEQ accepted.
    out_ready = 1'b0; in_valid = 1'b1; instruction = I_HALT;
    tick();
    in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_halted", {31'd0, halted}, 32'd0);
    chk("flush_run", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; instruction = I_BEQ;
    tick();
    chk("beq_valid", {31'd0, out_valid}, 32'd1);
    chk("beq_ctrl", ctrl_bits(), 32'b00010);
    chk("beq_halted", {31'd0, halted}, 32'd0);

    // Asynchronous reset mid-cycle with a bundle held.
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    chk("mid_rst_ctrl", ctrl_bits(), 32'd0);
    tick();
    rst = 1'b0;

`ifdef IDCTL_PERF_CNT_EN
    // 20 R-type handshakes saturate a 4-bit counter.
    out_ready = 1'b1; in_valid = 1'b1; instruction = I_R;
    repeat (20) tick();
    in_valid = 1'b0;
    tick();
    chk("sat_cnt_r", 32'(cnt_r), 32'd15);
    chk("sat_cnt_j", 32'(cnt_j), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered instruction-decode control stage for the MIPS32 pipeline, placed between the IF/ID boundary and the register-read/EX stages. Classifies each instruction as R, J, HALT or I-type and produces the per-instruction control bundle. Adds a valid/ready handshake, a flush input, and a RUN/DRAIN/HALTED state machine that stops instruction intake once a HALT has been issued downstream. Opcode encodings and widths are parameters.

## Interface
- `INSTR_W`, 32: instruction width.
- `OP_W`, 6: opcode width; opcode is `instruction[INSTR_W-1 -: OP_W]`.
- `OP_R`, 6'b000000: R-type opcode.
- `OP_J`, 6'b000010: jump opcode.
- `OP_HALT`, 6'b111111: halt opcode.
- `CNT_W`, 16: performance counter width. Used only with `IDCTL_PERF_CNT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `instruction` in INSTR_W: instruction word.
- `flush` in 1: synchronous squash of the held instruction.
- `out_valid` out 1: output bundle valid.
- `out_ready` in 1: downstream accepts the bundle.
- `out_instr` out INSTR_W: registered instruction.
- `out_opcode` out OP_W: registered opcode.
- `out_type` out 2: R=0, J=1, HALT=2, I=3.
- `reg_write`, `mem_read`, `mem_write`, `branch`, `jump` out 1 each: control bits.
- `halted` out 1: HALT has left the stage. Sticky until reset.
- `cnt_r`, `cnt_i`, `cnt_j` out CNT_W each: retired-type counters. Present only with the macro.

## Operation
- Instruction type: opcode==OP_R gives R; OP_J gives J; OP_HALT gives HALT; any other opcode gives I.
- Control bits by type:
  - R: reg_write.
  - J: jump.
  - HALT: no control bits set.
  - I, opcode 100011 (LW): mem_read and reg_write.
  - I, opcode 101011 (SW): mem_write.
  - I, opcode 000100 or 000101 (BEQ/BNE): branch.
  - I, opcode 001xxx: reg_write.
  - Any other I opcode: all control bits 0.
- `in_ready` = (state==RUN) && !flush && (!out_valid || out_ready).
- Accept: when in_valid && in_ready, the bundle register loads the decoded instruction and sets out_valid=1.
- Drain: if out_valid && out_ready and nothing is accepted, out_valid clears.
- States:
  - RUN: normal operation. Accepting a HALT moves to DRAIN.
  - DRAIN: in_ready=0. When the HALT handshakes downstream (out_valid && out_ready), move to HALTED and set halted=1.
  - HALTED: in_ready=0, out_valid=0. Only reset exits this state.
- Flush has priority over accept and drain:
  - Next cycle out_valid=0. Nothing is accepted in the flush cycle.
  - Flush in DRAIN squashes the HALT and returns the FSM to RUN. halted stays 0.
  - Flush in HALTED has no effect.
- Simultaneous out_ready and in_valid with a full register: the old bundle leaves and the new one loads in the same cycle, so throughput is 1 per cycle.

## Timing
- Decode-to-output latency: 1 cycle. All outputs except in_ready are registered.
- in_ready is combinational from state, out_valid, out_ready and flush.
- Reset values: out_valid=0, out_instr=0, out_opcode=0, out_type=0, all control bits 0, halted=0, state=RUN, counters 0.
- Reset asserted mid-operation drops any held bundle immediately and asynchronously.
- Bundle data is stable while out_valid && !out_ready.

## Configuration
- `IDCTL_PERF_CNT_EN` defined:
  - cnt_r, cnt_i and cnt_j increment by 1 on each downstream handshake of the matching type.
  - HALT handshakes are not counted.
  - Counters saturate at all-ones and are not affected by flush.
- Undefined: counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `id_ctrl_pkg` holds:
  - instruction-type enum (R/J/HALT/I),
  - FSM state enum (RUN/DRAIN/HALTED),
  - I-type opcode constants (LW, SW, BEQ, BNE, ALU-immediate prefix 001),
  - control-bundle struct.
- Sub-module `id_ctrl_decode`: purely combinational, opcode to type plus control bundle, parametrised by OP_W and the three opcode parameters.
- `id_ctrl_stage` contains the bundle register, the handshake logic, the FSM and the counters.

## Test plan
- Stream R(0x012A4020), LW(0x8C880004), J(0x08000010) with out_ready=1:
  - out_type 0, 3, 1 on consecutive cycles, 1-cycle latency.
  - LW has mem_read=1 and reg_write=1.
  - Counters read cnt_r=1, cnt_i=1, cnt_j=1.
- Hold out_ready=0 for 3 cycles with a bundle valid:
  - in_ready=0 and the bundle is stable.
  - On release, the next instruction loads in the same cycle.
- Accept HALT 0xFC000000 with out_ready=0:
  - in_ready=0 in DRAIN.
  - Raise out_ready: halted=1 on the next cycle, and in_ready stays 0 forever.
- HALT in DRAIN, then flush:
  - out_valid=0 and the FSM returns to RUN.
  - A following BEQ(0x10220003) is accepted with branch=1. halted=0.
- Assert rst asynchronously mid-stream with out_valid=1: all outputs return to reset values before the next clock edge.
- Under the macro with CNT_W=4, issue 20 R-type handshakes: cnt_r saturates at 15.
